// File: rtl/lane_issue_seq_if.sv
// lane_issue_seq_if: command, bank-conflict, retire and register-read signals of the lane issue sequencer.
interface lane_issue_seq_if #(parameter int IDX_W = 8, parameter int LEN_W = 8);
  logic             I_Cmd_Valid;
  logic             O_Cmd_Ready;
  logic [LEN_W-1:0] I_Cmd_Len;
  logic             I_Cmd_Use_Odd;
  logic             I_Cmd_Use_Even;
  logic [IDX_W-1:0] I_Cmd_Base_Odd;
  logic [IDX_W-1:0] I_Cmd_Base_Even;
  logic             I_WB_Odd;
  logic             I_WB_Even;
  logic             I_Stall;
  logic             I_Done;
  logic             O_Rd_Valid;
  logic             O_Rd_Odd_Req;
  logic             O_Rd_Even_Req;
  logic [IDX_W-1:0] O_Rd_Odd_Idx;
  logic [IDX_W-1:0] O_Rd_Even_Idx;
  logic             O_Rd_Last;
  logic             O_Commit;
  logic             O_Busy;
  logic             O_Err;
  modport master (
    output I_Cmd_Valid, I_Cmd_Len, I_Cmd_Use_Odd, I_Cmd_Use_Even, I_Cmd_Base_Odd, I_Cmd_Base_Even,
    output I_WB_Odd, I_WB_Even, I_Stall, I_Done,
    input  O_Cmd_Ready, O_Rd_Valid, O_Rd_Odd_Req, O_Rd_Even_Req, O_Rd_Odd_Idx, O_Rd_Even_Idx,
    input  O_Rd_Last, O_Commit, O_Busy, O_Err
  );
  modport slave (
    input  I_Cmd_Valid, I_Cmd_Len, I_Cmd_Use_Odd, I_Cmd_Use_Even, I_Cmd_Base_Odd, I_Cmd_Base_Even,
    input  I_WB_Odd, I_WB_Even, I_Stall, I_Done,
    output O_Cmd_Ready, O_Rd_Valid, O_Rd_Odd_Req, O_Rd_Even_Req, O_Rd_Odd_Idx, O_Rd_Even_Idx,
    output O_Rd_Last, O_Commit, O_Busy, O_Err
  );
endinterface

// File: rtl/lane_issue_seq.sv
// lane_issue_seq: turns one vector command into per-element odd/even bank read requests,
// stalling on write-back conflicts, back-pressure and the in-flight cap, then commits once all retire.
module lane_issue_seq #(
  parameter int IDX_W = 8,
  parameter int LEN_W = 8,
  parameter int MAX_INFLIGHT = 8
) (
  input logic clock,
  input logic reset,
  lane_issue_seq_if.slave bus
);
  localparam int IF_W = $clog2(MAX_INFLIGHT + 1);
  localparam logic [IF_W-1:0] MAX_IF = IF_W'(MAX_INFLIGHT);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
  state_t state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d, elem_cnt_q, elem_cnt_d;
  logic [IDX_W-1:0] base_odd_q, base_odd_d, base_even_q, base_even_d;
  logic use_odd_q, use_odd_d, use_even_q, use_even_d;
  logic [IF_W-1:0] inflight_q, inflight_d;
  logic err_q, err_d;
  logic stall, issue, last, done_ok, commit;
  always_comb begin
    state_d = state_q;
    len_d = len_q;
    elem_cnt_d = elem_cnt_q;
    base_odd_d = base_odd_q;
    base_even_d = base_even_q;
    use_odd_d = use_odd_q;
    use_even_d = use_even_q;
    stall = bus.I_Stall | (use_odd_q & bus.I_WB_Odd) | (use_even_q & bus.I_WB_Even) | (inflight_q == MAX_IF);
    issue = (state_q == ISSUE) & ~stall;
    last = elem_cnt_q == len_q - LEN_W'(1);
    // a retire only counts if something is (or is becoming) in flight
    done_ok = bus.I_Done & ((inflight_q != '0) | issue);
    inflight_d = inflight_q + IF_W'(issue) - IF_W'(done_ok);
    err_d = err_q | (bus.I_Done & ~done_ok);
    commit = (state_q == DRAIN) & (inflight_q == '0);
    if (state_q == IDLE && bus.I_Cmd_Valid) begin
      len_d = bus.I_Cmd_Len;
      use_odd_d = bus.I_Cmd_Use_Odd;
      use_even_d = bus.I_Cmd_Use_Even;
      base_odd_d = bus.I_Cmd_Base_Odd;
      base_even_d = bus.I_Cmd_Base_Even;
      elem_cnt_d = '0;
      state_d = bus.I_Cmd_Len == '0 ? DRAIN : ISSUE;
    end
    if (issue) begin
      elem_cnt_d = elem_cnt_q + LEN_W'(1);
      state_d = last ? DRAIN : ISSUE;
    end
    if (commit) state_d = IDLE;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      len_q <= '0;
      elem_cnt_q <= '0;
      base_odd_q <= '0;
      base_even_q <= '0;
      use_odd_q <= 1'b0;
      use_even_q <= 1'b0;
      inflight_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q <= len_d;
      elem_cnt_q <= elem_cnt_d;
      base_odd_q <= base_odd_d;
      base_even_q <= base_even_d;
      use_odd_q <= use_odd_d;
      use_even_q <= use_even_d;
      inflight_q <= inflight_d;
      err_q <= err_d;
    end
  end
  assign bus.O_Cmd_Ready = state_q == IDLE;
  assign bus.O_Rd_Valid = issue;
  assign bus.O_Rd_Odd_Req = issue & use_odd_q;
  assign bus.O_Rd_Even_Req = issue & use_even_q;
  assign bus.O_Rd_Odd_Idx = issue ? base_odd_q + IDX_W'(elem_cnt_q) : '0;
  assign bus.O_Rd_Even_Idx = issue ? base_even_q + IDX_W'(elem_cnt_q) : '0;
  assign bus.O_Rd_Last = issue & last;
  assign bus.O_Commit = commit;
  assign bus.O_Busy = state_q != IDLE;
  assign bus.O_Err = err_q;
endmodule

// File: tb/tb_lane_issue_seq.sv
// tb_lane_issue_seq: directed checks of the lane issue sequencer (default cap and a cap-of-2 instance).
module tb_lane_issue_seq;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int n_chk = 0;
  int n_pass = 0;
  lane_issue_seq_if a ();
  lane_issue_seq_if b ();
  lane_issue_seq u_a (.clock(clock), .reset(reset), .bus(a.slave));
  lane_issue_seq #(.MAX_INFLIGHT(2)) u_b (.clock(clock), .reset(reset), .bus(b.slave));
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
  endtask
  task automatic cmd(input int len, input logic uo, input logic ue, input int bo, input int be);
    a.I_Cmd_Valid = 1'b1;
    a.I_Cmd_Len = 8'(len);
    a.I_Cmd_Use_Odd = uo;
    a.I_Cmd_Use_Even = ue;
    a.I_Cmd_Base_Odd = 8'(bo);
    a.I_Cmd_Base_Even = 8'(be);
  endtask
  task automatic nxt;
    @(negedge clock);
    a.I_Cmd_Valid = 1'b0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n;
    int off;
    bit seen;
    {a.I_Cmd_Valid, a.I_Cmd_Len, a.I_Cmd_Use_Odd, a.I_Cmd_Use_Even, a.I_Cmd_Base_Odd, a.I_Cmd_Base_Even} = '0;
    {a.I_WB_Odd, a.I_WB_Even, a.I_Stall, a.I_Done} = '0;
    {b.I_Cmd_Valid, b.I_Cmd_Len, b.I_Cmd_Use_Odd, b.I_Cmd_Use_Even, b.I_Cmd_Base_Odd, b.I_Cmd_Base_Even} = '0;
    {b.I_WB_Odd, b.I_WB_Even, b.I_Stall, b.I_Done} = '0;
    repeat (2) @(negedge clock);
    #1;
    chk("rst_ready", a.O_Cmd_Ready, 1);
    chk("rst_busy", a.O_Busy, 0);
    chk("rst_valid", a.O_Rd_Valid, 0);
    chk("rst_commit", a.O_Commit, 0);
    chk("rst_err", a.O_Err, 0);
    reset = 1'b0;
    // len=4 odd only, each element retires the cycle after issue
    @(negedge clock);
    cmd(4, 1, 0, 8'h10, 0);
    for (int k = 1; k <= 7; k++) begin
      nxt();
      a.I_Done = k >= 2 && k <= 5;
      #1;
      chk("t1_valid", a.O_Rd_Valid, k <= 4);
      chk("t1_oreq", a.O_Rd_Odd_Req, k <= 4);
      chk("t1_ereq", a.O_Rd_Even_Req, 0);
      chk("t1_oidx", a.O_Rd_Odd_Idx, k <= 4 ? 32'h10 + k - 1 : 0);
      chk("t1_last", a.O_Rd_Last, k == 4);
      chk("t1_commit", a.O_Commit, k == 6);
      chk("t1_ready", a.O_Cmd_Ready, k == 7);
      chk("t1_busy", a.O_Busy, k != 7);
    end
    // len=3 both banks, even write-back conflict on the 2nd issue cycle
    cmd(3, 1, 1, 8'h20, 8'h40);
    for (int k = 1; k <= 8; k++) begin
      nxt();
      a.I_WB_Even = k == 2;
      a.I_Done = k >= 5 && k <= 7;
      #1;
      off = k == 1 ? 0 : k - 2;
      chk("t2_valid", a.O_Rd_Valid, k == 1 || k == 3 || k == 4);
      chk("t2_oidx", a.O_Rd_Odd_Idx, (k == 1 || k == 3 || k == 4) ? 32'h20 + off : 0);
      chk("t2_eidx", a.O_Rd_Even_Idx, (k == 1 || k == 3 || k == 4) ? 32'h40 + off : 0);
      chk("t2_last", a.O_Rd_Last, k == 4);
      chk("t2_commit", a.O_Commit, k == 8);
    end
    a.I_WB_Even = 1'b0;
    // odd-bank write-back while the command only reads the even bank
    @(negedge clock);
    cmd(2, 0, 1, 0, 8'h05);
    for (int k = 1; k <= 5; k++) begin
      nxt();
      a.I_WB_Odd = k <= 2;
      a.I_Done = k == 3 || k == 4;
      #1;
      chk("t3_valid", a.O_Rd_Valid, k <= 2);
      chk("t3_oreq", a.O_Rd_Odd_Req, 0);
      chk("t3_eidx", a.O_Rd_Even_Idx, k <= 2 ? 32'h05 + k - 1 : 0);
      chk("t3_last", a.O_Rd_Last, k == 2);
      chk("t3_commit", a.O_Commit, k == 5);
    end
    a.I_WB_Odd = 1'b0;
    // index wrap past 0xFF
    @(negedge clock);
    cmd(4, 1, 1, 8'hFE, 8'h00);
    for (int k = 1; k <= 6; k++) begin
      nxt();
      a.I_Done = k >= 2 && k <= 5;
      #1;
      chk("t4_oidx", a.O_Rd_Odd_Idx, k <= 4 ? (32'hFE + k - 1) % 256 : 0);
      chk("t4_eidx", a.O_Rd_Even_Idx, k <= 4 ? k - 1 : 0);
      chk("t4_commit", a.O_Commit, k == 6);
    end
    a.I_Done = 1'b0;
    // no-op command
    @(negedge clock);
    cmd(0, 1, 1, 8'h33, 8'h44);
    nxt();
    #1;
    chk("t5_valid", a.O_Rd_Valid, 0);
    chk("t5_commit", a.O_Commit, 1);
    chk("t5_ready", a.O_Cmd_Ready, 0);
    chk("t5_busy", a.O_Busy, 1);
    nxt();
    #1;
    chk("t5_ready2", a.O_Cmd_Ready, 1);
    chk("t5_commit2", a.O_Commit, 0);
    chk("t5_busy2", a.O_Busy, 0);
    // in-flight cap of 2, retirements withheld
    b.I_Cmd_Valid = 1'b1;
    b.I_Cmd_Len = 8'd5;
    b.I_Cmd_Use_Odd = 1'b1;
    n = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock);
      b.I_Cmd_Valid = 1'b0;
      b.I_Done = k == 4;
      #1;
      chk("t6_valid", b.O_Rd_Valid, k == 1 || k == 2 || k == 5);
      chk("t6_oidx", b.O_Rd_Odd_Idx, k == 5 ? 2 : (k <= 2 ? k - 1 : 0));
      chk("t6_commit", b.O_Commit, 0);
      if (b.O_Rd_Valid) n++;
    end
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clock);
      b.I_Done = 1'b1;
      #1;
      if (b.O_Rd_Valid) n++;
      seen = b.O_Commit;
    end
    b.I_Done = 1'b0;
    chk("t6_commit_seen", seen, 1);
    chk("t6_issues", n, 5);
    // retire while idle is an error that sticks
    @(negedge clock);
    a.I_Done = 1'b1;
    #1;
    chk("t7_err0", a.O_Err, 0);
    @(negedge clock);
    a.I_Done = 1'b0;
    #1;
    chk("t7_err1", a.O_Err, 1);
    repeat (3) @(negedge clock);
    #1;
    chk("t7_err_held", a.O_Err, 1);
    chk("t7_ready", a.O_Cmd_Ready, 1);
    // reset in the middle of a 6-element command
    @(negedge clock);
    cmd(6, 1, 0, 8'h30, 0);
    nxt();
    #1;
    chk("t8_idx0", a.O_Rd_Odd_Idx, 32'h30);
    nxt();
    #1;
    chk("t8_idx1", a.O_Rd_Odd_Idx, 32'h31);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    #1;
    chk("t8_ready", a.O_Cmd_Ready, 1);
    chk("t8_busy", a.O_Busy, 0);
    chk("t8_valid", a.O_Rd_Valid, 0);
    chk("t8_commit", a.O_Commit, 0);
    chk("t8_err", a.O_Err, 0);
    reset = 1'b0;
    cmd(1, 0, 1, 0, 8'h07);
    nxt();
    #1;
    chk("t8_new_valid", a.O_Rd_Valid, 1);
    chk("t8_new_eidx", a.O_Rd_Even_Idx, 32'h07);
    chk("t8_new_last", a.O_Rd_Last, 1);
    nxt();
    a.I_Done = 1'b1;
    #1;
    chk("t8_no_commit", a.O_Commit, 0);
    nxt();
    a.I_Done = 1'b0;
    #1;
    chk("t8_commit_new", a.O_Commit, 1);
    nxt();
    #1;
    chk("t8_ready_new", a.O_Cmd_Ready, 1);
    chk("t8_err_new", a.O_Err, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
